// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode ranges, field positions and the field-to-word encoder.
// The instruction decoder imports the same constants, so the two paths cannot drift apart.
package isa_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_R       = 4'd0;
  localparam logic [3:0] OP_I_FIRST = 4'd1;
  localparam logic [3:0] OP_I_LAST  = 4'd6;
  localparam logic [3:0] OP_J_FIRST = 4'd7;
  localparam logic [3:0] OP_J_LAST  = 4'd9;

  // Field LSB positions within the 16-bit word
  localparam int OPCODE_LSB = 12;
  localparam int FUNCT_LSB  = 9;
  localparam int RS_LSB     = 6;
  localparam int IMM_LSB    = 6;
  localparam int RT_LSB     = 3;
  localparam int RD_LSB     = 0;
  localparam int JADDR_LSB  = 0;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J,
    FMT_ILLEGAL
  } instr_fmt_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  funct;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [5:0]  imm;
    logic [11:0] addr;
  } instr_fields_t;

  function automatic instr_fmt_t instr_fmt(input logic [3:0] op);
    if (op == OP_R)                              return FMT_R;
    else if (op >= OP_I_FIRST && op <= OP_I_LAST) return FMT_I;
    else if (op >= OP_J_FIRST && op <= OP_J_LAST) return FMT_J;
    else                                         return FMT_ILLEGAL;
  endfunction

  function automatic instr_t encode_instr(input instr_fields_t f);
    instr_t w;
    // NOTE: give every combinational result a default before the case so no path leaves it unassigned (no latch).
    w = '0;
    unique case (instr_fmt(f.opcode))
      FMT_R: begin
        w[OPCODE_LSB +: 4] = OP_R;
        w[FUNCT_LSB  +: 3] = f.funct;
        w[RS_LSB     +: 3] = f.rs;
        w[RT_LSB     +: 3] = f.rt;
        w[RD_LSB     +: 3] = f.rd;
      end
      FMT_I: begin
        w[OPCODE_LSB +: 4] = f.opcode;
        w[IMM_LSB    +: 6] = f.imm;
        w[RT_LSB     +: 3] = f.rt;
        w[RD_LSB     +: 3] = f.rd;
      end
      FMT_J: begin
        w[OPCODE_LSB +: 4]  = f.opcode;
        w[JADDR_LSB  +: 12] = f.addr;
      end
      FMT_ILLEGAL: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; rdata shows the head entry whenever not empty.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_idx];

  // NOTE: storage is deliberately not reset; occupancy is tracked by the reset counters, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + PTR_ONE;
      if (do_pop)  rd_idx <= rd_idx + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction field tuples into 16-bit ISA words and streams them into
// instruction memory at contiguous addresses from a session start address.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [2:0]        in_funct,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [5:0]        in_imm,
  input  logic [11:0]       in_addr,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_wrap
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;

  instr_fields_t fields;
  instr_t        encoded;
  logic          legal;
  logic          accept;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  instr_t        fifo_head;

  assign fields = '{opcode: in_opcode, funct: in_funct, rs: in_rs, rt: in_rt,
                    rd: in_rd, imm: in_imm, addr: in_addr};
  assign encoded = encode_instr(fields);
  assign legal   = (instr_fmt(in_opcode) != FMT_ILLEGAL);

  // Ready only with a free slot: a full FIFO never accepts, even when a pop is in flight.
  assign in_ready  = (state == S_LOAD) && (fifo_count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign fifo_push = accept && legal && !fifo_full;
  assign fifo_pop  = mem_we && mem_ready;

  assign mem_we    = !fifo_empty;
  assign mem_addr  = wr_ptr;
  // Storage is not reset, so the data bus is forced quiet while nothing is queued.
  assign mem_wdata = fifo_empty ? '0 : fifo_head;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (encoded),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_wrap    <= 1'b0;
    end else begin
      if (fifo_pop) begin
        wr_ptr <= wr_ptr + ADDR_ONE;
        if (&wr_ptr) err_wrap <= 1'b1;
      end
      if (accept && !legal) err_illegal <= 1'b1;

      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD;
            wr_ptr      <= start_addr;
            busy        <= 1'b1;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_wrap    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept && in_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Empty FIFO means no write is pending, since mem_we tracks non-empty.
          if (fifo_empty) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
